// File: rtl/ifetch_prefetch_buffer.sv
// -----------------------------------------------------------------------------
// ifetch_prefetch_buffer
//
// Instruction prefetch queue sitting between the instruction memory port and
// the fetch stage. It runs ahead of the pipeline, issuing sequential word
// fetches. Returned instructions are kept with their PCs in an in-order FIFO
// and handed to fetch over a valid/ready interface. A redirect (branch, jump
// or interrupt) flushes the queue. Responses that are still in flight are
// silently dropped, and fetching restarts at the new PC.
//
// Optional feature macro: IFETCH_PREFETCH_ERR_EN
//   defined   : imem_rsp_err is stored per entry and shown on instr_err.
//               Issuing stops after a faulting word until the next redirect.
//   undefined : imem_rsp_err is ignored and instr_err is tied low.
//               No error storage is built.
//
// Parameters
//   DEPTH           FIFO entries, and the cap on queued plus outstanding
//                   requests (power of two, >= 2)
//   RESET_PC        first fetch address after reset
//   MAX_OUTSTANDING maximum number of un-responded imem requests
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   imem_req_valid/ready/addr     request channel to instruction memory
//   imem_rsp_valid/data/err       in-order response channel
//   redirect, redirect_addr       flush and restart at redirect_addr
//                                 (bits [1:0] of redirect_addr are ignored)
//   instr_valid/ready             head-of-queue handshake to fetch
//   instr, instr_pc,              head instruction, its PC, PC+4,
//   instr_pcPlus4, instr_err      and its fault flag
// -----------------------------------------------------------------------------
module ifetch_prefetch_buffer #(
    parameter int unsigned DEPTH           = 4,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pcPlus4,
    output logic        instr_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [31:0]      fetch_pc_reg;     // address of the next request
    logic [31:0]      rsp_pc_reg;       // PC tagged onto the next kept response
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [OUT_W-1:0] outstanding_reg;  // accepted requests not yet answered
    logic [OUT_W-1:0] discard_reg;      // answers still owed to a flushed stream

    logic [31:0] data_mem [DEPTH];
    logic [31:0] pc_mem   [DEPTH];

    // -------------------------------------------------------------------------
    // Combinational control
    // -------------------------------------------------------------------------
    logic [31:0]      redirect_pc;
    logic             credit_ok;
    logic             issue_block;
    logic             req_fire;
    logic             push;
    logic             pop;
    logic             drop;
    logic [CNT_W-1:0] count_next;
    logic [OUT_W-1:0] outstanding_next;
    logic [OUT_W-1:0] discard_next;

    assign redirect_pc = {redirect_addr[31:2], 2'b00};

    // Queued entries plus in-flight requests must never exceed DEPTH. Every
    // response then has a free slot, so no backpressure is needed on the
    // response channel.
    assign credit_ok = ((32'(count_reg) + 32'(outstanding_reg)) < DEPTH) &&
                       (32'(outstanding_reg) < MAX_OUTSTANDING);

    // rst is included so the request line is quiet while reset is held,
    // even though the counters already look "empty" then.
    assign imem_req_valid = !rst && !redirect && credit_ok && !issue_block;
    assign imem_req_addr  = fetch_pc_reg;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response is dropped when it belongs to a flushed stream.
    // This includes one arriving in the same cycle as the redirect itself.
    assign drop = imem_rsp_valid && (discard_reg != '0);
    assign push = imem_rsp_valid && !redirect && (discard_reg == '0);

    assign instr_valid = (count_reg != '0);
    assign pop         = instr_valid && instr_ready;

    always_comb begin
        outstanding_next = outstanding_reg;
        if (req_fire && !imem_rsp_valid) begin
            outstanding_next = outstanding_reg + OUT_W'(1);
        end else if (!req_fire && imem_rsp_valid) begin
            outstanding_next = outstanding_reg - OUT_W'(1);
        end
    end

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + CNT_W'(1);
        end else if (!push && pop) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    // On redirect, every request still in flight after this cycle belongs to
    // the old stream. That count replaces discard rather than adding to it,
    // because the old discard is already part of outstanding. This keeps
    // back-to-back redirects correct.
    always_comb begin
        discard_next = discard_reg;
        if (redirect) begin
            discard_next = outstanding_next;
        end else if (drop) begin
            discard_next = discard_reg - OUT_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_reg    <= RESET_PC;
            rsp_pc_reg      <= RESET_PC;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            outstanding_reg <= '0;
            discard_reg     <= '0;
        end else begin
            outstanding_reg <= outstanding_next;
            discard_reg     <= discard_next;
            if (redirect) begin
                fetch_pc_reg <= redirect_pc;
                rsp_pc_reg   <= redirect_pc;
                wr_ptr_reg   <= '0;
                rd_ptr_reg   <= '0;
                count_reg    <= '0;
            end else begin
                count_reg <= count_next;
                if (req_fire) begin
                    fetch_pc_reg <= fetch_pc_reg + 32'd4;   // wraps mod 2^32
                end
                if (push) begin
                    rsp_pc_reg <= rsp_pc_reg + 32'd4;
                    wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Entry storage. It needs no reset because the outputs are gated by
    // instr_valid. The head is read combinationally so fetch sees a new entry
    // the cycle after its response arrives.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_reg] <= imem_rsp_data;
            pc_mem[wr_ptr_reg]   <= rsp_pc_reg;
        end
    end

    assign instr         = instr_valid ? data_mem[rd_ptr_reg] : 32'd0;
    assign instr_pc      = instr_valid ? pc_mem[rd_ptr_reg]   : 32'd0;
    assign instr_pcPlus4 = instr_pc + 32'd4;

    // -------------------------------------------------------------------------
    // Optional fault tracking
    // -------------------------------------------------------------------------
`ifdef IFETCH_PREFETCH_ERR_EN
    logic err_mem [DEPTH];
    logic stop_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            err_mem[wr_ptr_reg] <= imem_rsp_err;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stop_reg <= 1'b0;
        end else if (redirect) begin
            stop_reg <= 1'b0;
        end else if (push && imem_rsp_err) begin
            stop_reg <= 1'b1;
        end
    end

    // The incoming faulting response also blocks issue in its own cycle.
    // Without this, a stream with single-cycle latency would still send one
    // request past the faulting address.
    assign issue_block = stop_reg || (push && imem_rsp_err);
    assign instr_err   = instr_valid ? err_mem[rd_ptr_reg] : 1'b0;
`else
    logic unused_rsp_err;
    assign unused_rsp_err = imem_rsp_err;
    assign issue_block    = 1'b0;
    assign instr_err      = 1'b0;
`endif

    // Redirect targets are always treated as word aligned.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^redirect_addr[1:0];

    // -------------------------------------------------------------------------
    // Simulation-only protocol checks
    // -------------------------------------------------------------------------
`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            // The credit check should make overflow impossible.
            assert (!(push && !pop && (count_reg == CNT_W'(DEPTH))));
            // A response with nothing outstanding means imem broke ordering.
            assert (!(imem_rsp_valid && (outstanding_reg == '0)));
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_prefetch_buffer.sv
// -----------------------------------------------------------------------------
// Directed testbench for ifetch_prefetch_buffer (DEPTH=4, RESET_PC=0x100,
// MAX_OUTSTANDING=2).
//
// A small in-order imem model answers each accepted request after 'lat'
// cycles. The answer data is mem_word(addr).
//
// Inputs change at the falling edge. Outputs are sampled 1 time unit later.
// Each delivered instruction is checked against a running expected PC, which
// is reset by the bench at each redirect or reset. The expected values at
// specific cycles were worked out by hand from the cycle-by-cycle behaviour.
// -----------------------------------------------------------------------------
module tb_ifetch_prefetch_buffer;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
`ifdef IFETCH_PREFETCH_ERR_EN
    localparam logic [31:0] ERR_ON = 32'd1;
`else
    localparam logic [31:0] ERR_ON = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pcPlus4;
    logic        instr_err;

    ifetch_prefetch_buffer #(
        .DEPTH           (4),
        .RESET_PC        (RST_PC),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .redirect       (redirect),
        .redirect_addr  (redirect_addr),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_pcPlus4  (instr_pcPlus4),
        .instr_err      (instr_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pq[$];
    int          cyc_n    = 0;
    int          lat      = 1;
    int          n_acc    = 0;
    int          acc0     = 0;
    logic [31:0] err_addr = 32'h0000_0001;
    logic [31:0] exp_pc   = RST_PC;

    logic [31:0] ob_req_valid;
    logic [31:0] ob_req_addr;
    logic [31:0] ob_instr_valid;
    logic [31:0] ob_pc;
    logic [31:0] ob_err;

    // One clock cycle. It is entered just after a falling edge, with the
    // control inputs already set by the caller.
    task automatic cyc();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        imem_rsp_err   = 1'b0;
        if (pq.size() > 0) begin
            if (pq[0].due == cyc_n) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(pq[0].addr);
                imem_rsp_err   = (pq[0].addr == err_addr);
                void'(pq.pop_front());
            end
        end
        #1;
        ob_req_valid   = 32'(imem_req_valid);
        ob_req_addr    = imem_req_addr;
        ob_instr_valid = 32'(instr_valid);
        ob_pc          = instr_pc;
        ob_err         = 32'(instr_err);
        if (imem_req_valid && imem_req_ready) begin
            pq.push_back('{imem_req_addr, cyc_n + lat});
            n_acc++;
        end
        if (instr_valid && instr_ready) begin
            $display("deliver pc=%08h instr=%08h err=%0b", instr_pc, instr, instr_err);
            check("sb_pc", instr_pc, exp_pc);
            check("sb_instr", instr, mem_word(exp_pc));
            check("sb_pc4", instr_pcPlus4, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
        end
        @(negedge clk);
        cyc_n++;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        redirect = 1'b0;
        pq.delete();
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_req_addr", imem_req_addr, RST_PC);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        check("rst_instr_err", 32'(instr_err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b0;
        exp_pc = RST_PC;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst            = 1'b1;
        redirect       = 1'b0;
        redirect_addr  = 32'd0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        imem_rsp_err   = 1'b0;
        instr_ready    = 1'b1;

        // Streaming from reset with a 1-cycle memory.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cyc();
            check("t1_req_valid", ob_req_valid, 32'd1);
            check("t1_req_addr", ob_req_addr, RST_PC + 32'(4 * i));
            check("t1_instr_valid", ob_instr_valid, (i >= 2) ? 32'd1 : 32'd0);
        end

        // Fetch stalled for 10 cycles: the FIFO fills to 4 and issue stops.
        instr_ready = 1'b0;
        acc0 = n_acc;
        repeat (10) cyc();
        check("t2_requests", n_acc - acc0, 32'd2);
        check("t2_req_valid", ob_req_valid, 32'd0);
        check("t2_instr_valid", ob_instr_valid, 32'd1);
        check("t2_head_pc", ob_pc, 32'h110);
        instr_ready = 1'b1;
        repeat (8) cyc();
        check("t2_drained", exp_pc, 32'h130);

        // Request held while imem is not ready.
        imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("t3_hold_valid", ob_req_valid, 32'd1);
            check("t3_hold_addr", ob_req_addr, 32'h13C);
        end

        // Redirect to 0x203 with two requests in flight (3-cycle memory).
        lat = 3;
        imem_req_ready = 1'b1;
        cyc();
        cyc();
        check("t3_pre_addr", ob_req_addr, 32'h140);
        redirect = 1'b1;
        redirect_addr = 32'h203;
        cyc();
        redirect = 1'b0;
        exp_pc = 32'h200;
        check("t3_redir_req_valid", ob_req_valid, 32'd0);
        cyc();
        check("t3_c30_addr", ob_req_addr, 32'h200);
        check("t3_c30_valid", ob_req_valid, 32'd0);
        check("t3_c30_instr_valid", ob_instr_valid, 32'd0);
        cyc();
        check("t3_c31_valid", ob_req_valid, 32'd1);
        check("t3_c31_addr", ob_req_addr, 32'h200);
        check("t3_c31_instr_valid", ob_instr_valid, 32'd0);
        cyc();
        check("t3_c32_addr", ob_req_addr, 32'h204);
        check("t3_c32_instr_valid", ob_instr_valid, 32'd0);
        cyc();
        cyc();
        check("t3_c34_instr_valid", ob_instr_valid, 32'd0);
        cyc();
        check("t3_first_valid", ob_instr_valid, 32'd1);
        check("t3_first_pc", ob_pc, 32'h200);

        // Redirect in the same cycle as a response and a pop.
        repeat (7) cyc();
        redirect = 1'b1;
        redirect_addr = 32'h300;
        cyc();
        redirect = 1'b0;
        check("t4_pop_valid", ob_instr_valid, 32'd1);
        check("t4_pop_pc", ob_pc, 32'h210);
        exp_pc = 32'h300;
        cyc();
        check("t4_empty", ob_instr_valid, 32'd0);
        check("t4_req_valid", ob_req_valid, 32'd1);
        check("t4_req_addr", ob_req_addr, 32'h300);
        repeat (4) cyc();
        check("t4_delivered", exp_pc, 32'h304);

        // Address wrap at the top of memory.
        imem_req_ready = 1'b0;
        repeat (4) cyc();
        lat = 1;
        imem_req_ready = 1'b1;
        redirect = 1'b1;
        redirect_addr = 32'hFFFF_FFFE;
        cyc();
        redirect = 1'b0;
        exp_pc = 32'hFFFF_FFFC;
        cyc();
        check("t5_req_valid0", ob_req_valid, 32'd1);
        check("t5_req_addr0", ob_req_addr, 32'hFFFF_FFFC);
        cyc();
        check("t5_req_valid1", ob_req_valid, 32'd1);
        check("t5_req_addr1", ob_req_addr, 32'h0000_0000);
        repeat (3) cyc();
        check("t5_wrap_delivered", exp_pc, 32'h8);

        // Reset mid-run, then a fault on the word at 0x108.
        err_addr = 32'h108;
        do_reset();
        repeat (3) cyc();
        cyc();
`ifdef IFETCH_PREFETCH_ERR_EN
        check("t6_c3_req_valid", ob_req_valid, 32'd0);
`else
        check("t6_c3_req_valid", ob_req_valid, 32'd1);
        check("t6_c3_req_addr", ob_req_addr, 32'h10C);
`endif
        cyc();
        check("t6_err_valid", ob_instr_valid, 32'd1);
        check("t6_err_pc", ob_pc, 32'h108);
        check("t6_err_flag", ob_err, ERR_ON);
`ifdef IFETCH_PREFETCH_ERR_EN
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("t6_stopped", ob_req_valid, 32'd0);
            check("t6_stop_addr", ob_req_addr, 32'h10C);
        end
`else
        repeat (3) cyc();
`endif
        redirect = 1'b1;
        redirect_addr = 32'h400;
        cyc();
        redirect = 1'b0;
        exp_pc = 32'h400;
        cyc();
        check("t6_restart_valid", ob_req_valid, 32'd1);
        check("t6_restart_addr", ob_req_addr, 32'h400);
        repeat (3) cyc();
        check("t6_post_delivered", exp_pc, 32'h408);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ifetch_prefetch_buffer.md
Name: ifetch_prefetch_buffer

Overview:
- Instruction prefetch queue between the instruction memory port and the fetch stage.
- Issues sequential word fetches ahead of the pipeline and holds returned instructions with their PCs in an in-order FIFO.
- Hands instructions to fetch over a valid/ready interface.
- On a branch/jump/interrupt redirect, drops queued and in-flight instructions and restarts at the new PC.

Parameters:
- DEPTH, 4: FIFO entries; also the cap on queued plus outstanding requests; power of two, at least 2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- MAX_OUTSTANDING, 2: maximum un-responded imem requests.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  imem accepts request this cycle.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_rsp_valid  in  1  response valid; responses arrive in request order, at least 1 cycle after acceptance.
- imem_rsp_data  in  32  instruction word.
- imem_rsp_err  in  1  access fault for this response.
- redirect  in  1  flush and restart, from pc_next_sel or interrupt_en.
- redirect_addr  in  32  new PC; bits [1:0] are ignored and treated as 0.
- instr_valid  out  1  head entry is valid.
- instr_ready  in  1  fetch consumes head this cycle; deasserted while stall_IF is asserted.
- instr  out  32  head instruction.
- instr_pc  out  32  PC of head instruction.
- instr_pcPlus4  out  32  instr_pc + 4.
- instr_err  out  1  head entry faulted (see Optional Feature).

Behaviour:
- Reset state (async, while rst=1):
  - fetch_pc = RESET_PC and rsp_pc = RESET_PC.
  - FIFO empty; outstanding = 0; discard = 0.
  - instr_valid = 0, imem_req_valid = 0, instr/instr_pc/instr_err = 0.
- Reset mid-operation aborts everything. Responses to pre-reset requests are a system-level invariant: imem is reset together with this block.
- Request issue:
  - imem_req_valid = !redirect && (count + outstanding < DEPTH) && (outstanding < MAX_OUTSTANDING).
  - imem_req_addr = fetch_pc.
  - On accept (valid & ready): fetch_pc += 4, wrapping modulo 2^32; outstanding += 1.
  - Address is held stable while valid is high and ready is low, unless a redirect occurs.
- Response:
  - Every imem_rsp_valid decrements outstanding. Accept and response in the same cycle leave it unchanged.
  - If discard > 0: the response is dropped and discard -= 1.
  - Otherwise push {imem_rsp_data, rsp_pc, imem_rsp_err} and rsp_pc += 4.
  - The credit check guarantees no overflow. A push into a full FIFO is a protocol error; flag it with an assertion in simulation only.
- Output:
  - instr_valid = (count != 0); the head fields drive instr/instr_pc/instr_err.
  - Pop on instr_valid & instr_ready.
  - Simultaneous push and pop keeps count constant; this is legal at full and at empty+1.
  - Zero-latency bypass is not provided: a response is visible to fetch the cycle after it arrives.
- Redirect (takes effect at the next edge):
  - FIFO cleared.
  - fetch_pc and rsp_pc set to {redirect_addr[31:2], 2'b00}.
  - discard = outstanding_next, i.e. outstanding after this cycle's response, including any response arriving this cycle, which is itself dropped.
  - imem_req_valid is 0 in the redirect cycle. A pop in the redirect cycle is allowed but irrelevant.
  - The first post-redirect request issues the cycle after redirect.
  - Back-to-back redirects: the last one wins; discard accumulates correctly from the current outstanding count.
- Counters: count is log2(DEPTH)+1 bits. outstanding and discard are each sized to hold MAX_OUTSTANDING.

Optional Feature:
- Macro: IFETCH_PREFETCH_ERR_EN.
- Defined:
  - imem_rsp_err is stored per entry and driven on instr_err.
  - After pushing an errored entry, issuing stops (imem_req_valid = 0) until redirect, so no fetches are issued past a fault.
- Undefined:
  - imem_rsp_err is ignored, instr_err is tied to 0, and no error storage is synthesized.

Test Plan:
- Reset with RESET_PC=0x100, imem ready, 1-cycle latency, instr_ready=1 -> requests 0x100, 0x104, 0x108 on consecutive cycles; instr_pc sequence 0x100, 0x104, ... with instr_pcPlus4 = pc + 4.
- instr_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 entries fill, imem_req_valid drops, and no response is lost after release.
- Redirect to 0x203 with 2 requests outstanding -> those 2 responses are dropped; next request address 0x200; first delivered instr_pc = 0x200.
- Redirect coinciding with imem_rsp_valid and a pop -> FIFO empty next cycle, discard equals remaining outstanding, and no stale PC appears.
- fetch_pc=0xFFFF_FFFC -> next request address 0x0000_0000.
- With IFETCH_PREFETCH_ERR_EN: rsp_err on the response for 0x108 -> instr_err=1 with instr_pc=0x108, no request to 0x10C until redirect. Without the macro, instr_err stays 0.
